// File: rtl/sound_pkg.sv
// Shared sound-path types and constants: sample/PCM widths and the
// unsigned-to-signed PCM conversion used by the I2S transmitter.
package sound_pkg;

   localparam int unsigned SAMPLE_W       = 10;
   localparam int unsigned PCM_W          = 24;
   localparam int unsigned SLOTS_PER_HALF = 32;

   typedef logic [PCM_W-1:0]    pcm24_t;
   typedef logic [SAMPLE_W-1:0] sample_t;

   // MSB invert turns offset-binary into two's complement; left-justify to 24 bits.
   function automatic pcm24_t to_pcm24(input sample_t sample);
      return {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0], {(PCM_W-SAMPLE_W){1'b0}}};
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter for the I2S transmitter and the decode of
// MCLK, SCLK, LRCK, bit slot and end-of-frame from its fields.
module i2s_clk_gen
   import sound_pkg::*;
#(
   parameter int unsigned MCLK_DIV_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       mclk,
   output logic       sclk,
   output logic       lrck,
   output logic [4:0] slot,
   output logic       frame_end
);

   localparam int unsigned L = MCLK_DIV_LOG2 + 8;

   logic [L-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      mclk      = cnt[L-9];
      sclk      = cnt[L-7];
      slot      = cnt[L-2:L-6];
      lrck      = cnt[L-1];
      frame_end = en && (cnt == '1);
   end

endmodule

// File: rtl/sound_i2s_tx.sv
// Output stage of the sound path: captures one sample per frame, converts it
// to 24-bit signed PCM and serialises it as mono-duplicated I2S.
module sound_i2s_tx
   import sound_pkg::*;
#(
   parameter int unsigned MCLK_DIV_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       mute,
   input  logic [9:0] sample_in,
   output logic       sample_tick,
   output logic       i2s_mclk,
   output logic       i2s_lrck,
   output logic       i2s_sclk,
   output logic       i2s_sdin
);

   logic       mclk_d;
   logic       sclk_d;
   logic       lrck_d;
   logic [4:0] slot;
   logic       frame_end;
   logic       sdin_next;
   pcm24_t     word;

   i2s_clk_gen #(
      .MCLK_DIV_LOG2(MCLK_DIV_LOG2)
   ) u_clk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mclk      (mclk_d),
      .sclk      (sclk_d),
      .lrck      (lrck_d),
      .slot      (slot),
      .frame_end (frame_end)
   );

   assign sample_tick = frame_end;

   // The only update point for word: mid-frame sample/mute changes wait for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= '0;
      end else if (frame_end) begin
         word <= mute ? '0 : to_pcm24(sample_in);
      end
   end

   // Slot 0 carries the I2S one-bit delay; slots past the word are zero padding.
   always_comb begin
      sdin_next = 1'b0;
      if (slot >= 5'd1 && slot <= 5'(PCM_W)) begin
         sdin_next = word[5'(PCM_W) - slot];
      end
   end

   // All pins share one register stage so their edge relationships are exact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i2s_mclk <= 1'b0;
         i2s_sclk <= 1'b0;
         i2s_lrck <= 1'b0;
         i2s_sdin <= 1'b0;
      end else if (!en) begin
         i2s_mclk <= 1'b0;
         i2s_sclk <= 1'b0;
         i2s_lrck <= 1'b0;
         i2s_sdin <= 1'b0;
      end else begin
         i2s_mclk <= mclk_d;
         i2s_sclk <= sclk_d;
         i2s_lrck <= lrck_d;
         i2s_sdin <= sdin_next;
      end
   end

endmodule

// File: tb/tb_sound_i2s_tx.sv
// Directed-plus-random bench for sound_i2s_tx against a frame-position reference model.
module tb_sound_i2s_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       mute = 1'b0;
   logic [9:0] sample_in = '0;
   logic       sample_tick;
   logic       i2s_mclk;
   logic       i2s_lrck;
   logic       i2s_sclk;
   logic       i2s_sdin;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state: position within the 1024-clk frame and the held word
   int          pos = 0;
   logic [23:0] m_word = '0;
   logic        m_mclk = 1'b0, m_sclk = 1'b0, m_lrck = 1'b0, m_sdin = 1'b0;
   logic        saw_tick = 1'b0;

   // deserialiser of the observed pins
   logic [63:0] rx = '0;
   logic [31:0] last_half = '0;
   logic        prev_sclk = 1'b0, prev_lrck = 1'b0;

   sound_i2s_tx #(.MCLK_DIV_LOG2(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .mute        (mute),
      .sample_in   (sample_in),
      .sample_tick (sample_tick),
      .i2s_mclk    (i2s_mclk),
      .i2s_lrck    (i2s_lrck),
      .i2s_sclk    (i2s_sclk),
      .i2s_sdin    (i2s_sdin)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [23:0] ref_pcm(input logic [9:0] s);
      int v;
      v = int'(s) - 512;
      return 24'(v * 16384);
   endfunction

   function automatic logic [31:0] half_of(input logic [23:0] w);
      return {1'b0, w, 7'b0};
   endfunction

   // Called at posedge+1 with inputs already set for the coming edge.
   task automatic cycle();
      int slot;
      #1;
      saw_tick = sample_tick;
      chk("tick", {31'b0, sample_tick}, {31'b0, (en && pos == 1023)});
      @(posedge clk);
      if (en) begin
         slot   = (pos / 16) % 32;
         m_mclk = ((pos / 2) % 2) == 1;
         m_sclk = ((pos / 8) % 2) == 1;
         m_lrck = (pos / 512) == 1;
         m_sdin = (slot >= 1 && slot <= 24) ? m_word[24 - slot] : 1'b0;
         if (pos == 1023) m_word = mute ? 24'h0 : ref_pcm(sample_in);
         pos = (pos + 1) % 1024;
      end else begin
         {m_mclk, m_sclk, m_lrck, m_sdin} = '0;
         pos = 0;
      end
      #1;
      chk("mclk", {31'b0, i2s_mclk}, {31'b0, m_mclk});
      chk("sclk", {31'b0, i2s_sclk}, {31'b0, m_sclk});
      chk("lrck", {31'b0, i2s_lrck}, {31'b0, m_lrck});
      chk("sdin", {31'b0, i2s_sdin}, {31'b0, m_sdin});
      if (i2s_sclk && !prev_sclk) rx = {rx[62:0], i2s_sdin};
      if (i2s_lrck != prev_lrck) last_half = rx[31:0];
      prev_sclk = i2s_sclk;
      prev_lrck = i2s_lrck;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_to_tick();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 2100 && !got; i++) begin
         cycle();
         got = saw_tick;
      end
      if (!got) chk("tick_timeout", 32'd0, 32'd1);
   endtask

   // Asserts reset between edges, checks pins drop at once, releases after the next edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_tick", {31'b0, sample_tick}, 32'd0);
      chk("rst_pins", {28'b0, i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdin}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pos = 0;
      m_word = '0;
      {m_mclk, m_sclk, m_lrck, m_sdin} = '0;
      prev_sclk = 1'b0;
      prev_lrck = 1'b0;
   endtask

   initial begin
      do_reset();
      run(5);

      // full scale, then close out a frame so last_half holds the right channel
      en = 1'b1;
      sample_in = 10'h3FF;
      run_to_tick();
      run_to_tick();
      cycle();
      chk("full_scale", last_half, half_of(24'h7FC000));

      sample_in = 10'h200;
      run_to_tick();
      run_to_tick();
      cycle();
      chk("silence", last_half, half_of(24'h000000));

      sample_in = 10'h000;
      run_to_tick();
      run_to_tick();
      cycle();
      chk("neg_full", last_half, half_of(24'h800000));

      // mute mid-frame: current frame unaffected, next frame zero
      sample_in = 10'h3FF;
      run_to_tick();
      run(300);
      mute = 1'b1;
      run_to_tick();
      cycle();
      chk("mute_cur", last_half, half_of(24'h7FC000));
      run_to_tick();
      cycle();
      chk("mute_next", last_half, half_of(24'h000000));
      mute = 1'b0;

      // random samples with a mid-frame change the transmitter must ignore
      for (int f = 0; f < 6; f++) begin
         sample_in = 10'($urandom);
         run(int'($urandom_range(50, 900)));
         sample_in = 10'($urandom);
         run_to_tick();
      end

      // disable mid-frame, then re-enable from the retained word
      run(200);
      en = 1'b0;
      cycle();
      chk("dis_pins", {28'b0, i2s_mclk, i2s_sclk, i2s_lrck, i2s_sdin}, 32'd0);
      sample_in = 10'($urandom);
      run(40);
      en = 1'b1;
      run_to_tick();
      sample_in = 10'h155;
      run_to_tick();
      run(2);
      en = 1'b0;
      run(20);
      en = 1'b1;
      run(1030);
      chk("reenable_half", last_half, half_of(ref_pcm(10'h155)));

      // async reset mid-frame, then restart and check a fresh sample
      run(100);
      do_reset();
      sample_in = 10'h0AA;
      run_to_tick();
      run_to_tick();
      cycle();
      chk("post_reset", last_half, half_of(ref_pcm(10'h0AA)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
